// File: rtl/mul_share_arbiter.sv
// ---------------------------------------------------------------------------
// mul_share_arbiter
//
// Two requesters share one iterative signed multiplier. A round-robin arbiter
// in IDLE grants one request. The shared datapath then runs WIDTH radix-2
// Booth steps and presents the 2*WIDTH-bit product on a valid/ready response
// port. The response also carries the id of the requester that produced it.
//
// Ports
//   clk                      rising-edge clock
//   reset                    asynchronous, active-high reset
//   en                       global advance enable (0 = all state holds)
//   req0_valid / req1_valid  operand request from port 0 / 1
//   req0_ready / req1_ready  request accepted on an edge with valid & ready
//   req0_a, req0_b           port 0 signed operands (WIDTH bits each)
//   req1_a, req1_b           port 1 signed operands (WIDTH bits each)
//   rsp_valid                result available
//   rsp_ready                consumer takes the result on valid & ready
//   rsp_id                   port index that produced rsp_result
//   rsp_result               signed product (2*WIDTH bits)
//   busy                     high whenever the FSM is not in IDLE
//   done_count               completed response handshakes, mod 2^CNTW
// ---------------------------------------------------------------------------
module mul_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 req0_valid,
    input  logic                 req1_valid,
    output logic                 req0_ready,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_result,
    output logic                 busy,
    output logic [CNTW-1:0]      done_count
);

    localparam int SW = $clog2(WIDTH + 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    state_e               state_q, state_d;
    logic                 last_q, last_d;       // port granted most recently
    logic                 id_q, id_d;           // port of the in-flight operation
    logic [WIDTH:0]       mcand_q, mcand_d;     // sign-extended multiplicand
    logic [WIDTH:0]       acc_q, acc_d;         // upper half of the Booth register
    logic [WIDTH-1:0]     mplier_q, mplier_d;   // lower half, shifts the multiplier out
    logic                 qm1_q, qm1_d;         // Booth q(-1) bit
    logic [SW-1:0]        step_q, step_d;
    logic [2*WIDTH-1:0]   res_q, res_d;
    logic                 rid_q, rid_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;

    // -----------------------------------------------------------------------
    // Arbitration: on a tie, grant the port that was not granted last.
    // -----------------------------------------------------------------------
    logic grant;
    logic accept;

    assign grant  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign accept = (state_q == ST_IDLE) && en && (req0_valid || req1_valid);

    // Readies are gated by reset as well. While reset is held, the FSM is
    // already forced to IDLE, and without the gate IDLE would advertise a grant.
    assign req0_ready = accept && !grant && !reset;
    assign req1_ready = accept &&  grant && !reset;

    // -----------------------------------------------------------------------
    // One radix-2 Booth step. It adds or subtracts the multiplicand based on
    // {Q[0], q(-1)} and then arithmetic-shifts {acc, mplier, qm1} right by
    // one. The extra multiplicand bit keeps -2^(WIDTH-1) exact.
    // -----------------------------------------------------------------------
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   acc_n;
    logic [WIDTH-1:0] mplier_n;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path can leave it unassigned and infer a latch.
        booth_sum = acc_q;
        case ({mplier_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + mcand_q;
            2'b10:   booth_sum = acc_q - mcand_q;
            default: booth_sum = acc_q;
        endcase
        acc_n    = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        mplier_n = {booth_sum[0], mplier_q[WIDTH-1:1]};
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        id_d     = id_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        qm1_d    = qm1_q;
        step_d   = step_q;
        res_d    = res_q;
        rid_d    = rid_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    id_d     = grant;
                    last_d   = grant;
                    mcand_d  = grant ? {req1_a[WIDTH-1], req1_a}
                                     : {req0_a[WIDTH-1], req0_a};
                    mplier_d = grant ? req1_b : req0_b;
                    acc_d    = '0;
                    qm1_d    = 1'b0;
                    step_d   = '0;
                    state_d  = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (en) begin
                    acc_d    = acc_n;
                    mplier_d = mplier_n;
                    qm1_d    = mplier_q[0];
                    step_d   = step_q + SW'(1);
                    if (step_q == LAST_STEP) begin
                        // The full product fits in the low 2*WIDTH bits of
                        // {acc, mplier}. The top acc bit is only a sign copy.
                        res_d   = {acc_n[WIDTH-1:0], mplier_n};
                        rid_d   = id_q;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                if (en && rsp_ready) begin
                    cnt_d   = cnt_q + CNTW'(1);
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values no matter how the blocks are ordered.
        if (reset) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;       // port 0 wins the first tie
            id_q     <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            qm1_q    <= 1'b0;
            step_q   <= '0;
            res_q    <= '0;
            rid_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            qm1_q    <= qm1_d;
            step_q   <= step_d;
            res_q    <= res_d;
            rid_q    <= rid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rsp_valid  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_id     = rid_q;
    assign rsp_result = res_q;
    assign done_count = cnt_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;

    localparam int W  = 32;
    localparam int CW = 4;   // small counter so the wrap is reachable quickly

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [2*W-1:0] rsp_result;
    logic          busy;
    logic [CW-1:0] done_count;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference state: round-robin pointer and handshake count
    bit m_last;
    int m_count;

    mul_share_arbiter #(.WIDTH(W), .CNTW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        en         = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        repeat (2) tick();
        reset   = 1'b0;
        m_last  = 1'b1;
        m_count = 0;
    endtask

    // Present a single-port request and wait, within a bound, until it is accepted.
    task automatic start_op(input bit port, input int a, input int b, output bit ok);
        ok = 1'b0;
        if (port) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((port ? req1_ready : req0_ready) === 1'b1) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
        if (ok) m_last = port;
    endtask

    // Count edges after the accept until rsp_valid shows up.
    task automatic wait_rsp(output int n_all, output bit ok);
        n_all = 0;
        ok    = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n_all++;
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        m_count = (m_count + 1) % (1 << CW);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        reset      = 1'b1;
        en         = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready  = 1'b0;
        #12;
        tests_run++;
        if ({busy, rsp_valid, rsp_id, req0_ready, req1_ready} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 00000", {busy, rsp_valid, rsp_id, req0_ready, req1_ready});
        end
        tests_run++;
        if (rsp_result !== 64'd0 || done_count !== '0) begin
            tests_failed++;
            $display("FAIL reset_values: result %0h count %0d expected 0 0", rsp_result, done_count);
        end
        tick();
        reset   = 1'b0;
        m_last  = 1'b1;
        m_count = 0;
        #1;
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_first_tie: got %b expected 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok; int n;
        apply_reset();
        start_op(1'b0, 5, -7, ok);
        wait_rsp(n, ok);
        tests_run++;
        if (!ok || n != W) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d edges (ok=%0d) expected %0d", n, ok, W);
        end
        tests_run++;
        if (rsp_id !== 1'b0 || rsp_result !== ref_mul(5, -7)) begin
            tests_failed++;
            $display("FAIL basic_result: got id %0d %0h expected id 0 %0h", rsp_id, rsp_result, ref_mul(5, -7));
        end
        handshake();
        tests_run++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_count !== CW'(m_count)) begin
            tests_failed++;
            $display("FAIL basic_done: valid %0d busy %0d count %0d expected 0 0 %0d", rsp_valid, busy, done_count, m_count);
        end
    endtask

    task automatic test_arbitration();
        int pa[2] = '{-12, -9};
        int pb[2] = '{-4, 5};
        bit g; bit ok; int n;
        apply_reset();
        req0_valid = 1'b1; req0_a = pa[0]; req0_b = pb[0];
        req1_valid = 1'b1; req1_a = pa[1]; req1_b = pb[1];
        for (int k = 0; k < 4; k++) begin
            g = ~m_last;
            #1;
            tests_run++;
            if (req0_ready !== !g || req1_ready !== g) begin
                tests_failed++;
                $display("FAIL arb_grant%0d: got %b expected %b", k, {req0_ready, req1_ready}, {!g, g});
            end
            tick();
            m_last = g;
            #1;
            tests_run++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                tests_failed++;
                $display("FAIL arb_ready_busy%0d: got %b expected 00", k, {req0_ready, req1_ready});
            end
            wait_rsp(n, ok);
            tests_run++;
            if (!ok || rsp_id !== g || rsp_result !== ref_mul(pa[g], pb[g])) begin
                tests_failed++;
                $display("FAIL arb_rsp%0d: got id %0d %0h expected id %0d %0h", k, rsp_id, rsp_result, g, ref_mul(pa[g], pb[g]));
            end
            handshake();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_corners();
        int ca[5] = '{32'h8000_0000, 32'h8000_0000, 11, -1, 32'h7FFF_FFFF};
        int cb[5] = '{32'h8000_0000, 1, 0, -7, 32'h7FFF_FFFF};
        logic [63:0] ce[5] = '{64'h4000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000,
                               64'd0, 64'd7, 64'h3FFF_FFFF_0000_0001};
        bit ok; int n;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            start_op(k[0], ca[k], cb[k], ok);
            wait_rsp(n, ok);
            tests_run++;
            if (!ok || rsp_result !== ce[k] || rsp_id !== k[0]) begin
                tests_failed++;
                $display("FAIL corner%0d: got id %0d %0h expected id %0d %0h", k, rsp_id, rsp_result, k[0], ce[k]);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        bit ok; int n; logic [63:0] exp;
        apply_reset();
        exp = ref_mul(-3, 77);
        start_op(1'b1, -3, 77, ok);
        wait_rsp(n, ok);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== exp ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold%0d: valid %0d id %0d res %0h rdy %b expected 1 1 %0h 00",
                         k, rsp_valid, rsp_id, rsp_result, {req0_ready, req1_ready}, exp);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        handshake();
        tests_run++;
        if (rsp_valid !== 1'b0 || done_count !== CW'(m_count) || rsp_result !== exp) begin
            tests_failed++;
            $display("FAIL hold_release: valid %0d count %0d res %0h expected 0 %0d %0h", rsp_valid, done_count, rsp_result, m_count, exp);
        end
    endtask

    task automatic test_enable_stall();
        bit ok; int n;
        apply_reset();
        start_op(1'b0, 1234, -5678, ok);
        repeat (10) tick();
        en = 1'b0;
        repeat (5) tick();
        tests_run++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_freeze: busy %0d valid %0d expected 1 0", busy, rsp_valid);
        end
        en = 1'b1;
        wait_rsp(n, ok);
        tests_run++;
        if (!ok || n + 15 != W + 5 || rsp_result !== ref_mul(1234, -5678)) begin
            tests_failed++;
            $display("FAIL stall_latency: got %0d edges %0h expected %0d %0h", n + 15, rsp_result, W + 5, ref_mul(1234, -5678));
        end
        en        = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        tests_run++;
        if (rsp_valid !== 1'b1 || done_count !== '0) begin
            tests_failed++;
            $display("FAIL stall_hs_blocked: valid %0d count %0d expected 1 0", rsp_valid, done_count);
        end
        en = 1'b1;
        tick();
        rsp_ready = 1'b0;
        m_count = 1;
        tests_run++;
        if (rsp_valid !== 1'b0 || done_count !== CW'(m_count)) begin
            tests_failed++;
            $display("FAIL stall_hs: valid %0d count %0d expected 0 1", rsp_valid, done_count);
        end
        en = 1'b0;
        req1_valid = 1'b1;
        #1;
        tests_run++;
        if (req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_en0_ready: got %0d expected 0", req1_ready);
        end
        req1_valid = 1'b0;
        en = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        bit ok; int n; bit seen;
        apply_reset();
        start_op(1'b0, 9, 9, ok);
        repeat (5) tick();
        req0_valid = 1'b1;
        #3 reset = 1'b1;
        #1;
        tests_run++;
        if ({busy, rsp_valid, req0_ready, req1_ready} !== 4'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got %b expected 0000", {busy, rsp_valid, req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        tick();
        reset   = 1'b0;
        m_last  = 1'b1;
        m_count = 0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (rsp_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL discard: got stray activity %0d expected 0", seen);
        end
        start_op(1'b0, 2, 3, ok);
        wait_rsp(n, ok);
        handshake();
        tests_run++;
        if (!ok || rsp_result !== 64'd6 || done_count !== CW'(1)) begin
            tests_failed++;
            $display("FAIL after_reset: got %0h count %0d expected 6 1", rsp_result, done_count);
        end
    endtask

    task automatic test_random();
        int a[2]; int b[2];
        bit v0, v1, g, ok, pre;
        int n_en;
        logic [63:0] exp;
        apply_reset();
        for (int k = 0; k < 24; k++) begin
            v0 = 1'b0; v1 = 1'b0;
            while (!v0 && !v1) begin
                v0 = 1'($urandom_range(0, 1));
                v1 = 1'($urandom_range(0, 1));
            end
            for (int p = 0; p < 2; p++) begin
                a[p] = int'($urandom);
                b[p] = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : int'($urandom);
            end
            g = (v0 && v1) ? ~m_last : v1;
            req0_valid = v0; req0_a = a[0]; req0_b = b[0];
            req1_valid = v1; req1_a = a[1]; req1_b = b[1];
            ok = 1'b0;
            for (int i = 0; i < 30 && !ok; i++) begin
                en = ($urandom_range(0, 3) != 0);
                #1;
                tests_run++;
                if (req0_ready !== (en && v0 && !g) || req1_ready !== (en && v1 && g)) begin
                    tests_failed++;
                    $display("FAIL rnd_grant%0d: got %b expected %b", k, {req0_ready, req1_ready}, {en && v0 && !g, en && v1 && g});
                end
                ok = en;
                tick();
            end
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            m_last = g;
            exp = ref_mul(a[g], b[g]);
            n_en = 0;
            ok = 1'b0;
            for (int i = 0; i < 300; i++) begin
                pre = ($urandom_range(0, 3) != 0);
                en = pre;
                tick();
                if (pre) n_en++;
                if (rsp_valid === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
            end
            tests_run++;
            if (!ok || n_en != W || rsp_id !== g || rsp_result !== exp) begin
                tests_failed++;
                $display("FAIL rnd_rsp%0d: steps %0d id %0d %0h expected %0d %0d %0h", k, n_en, rsp_id, rsp_result, W, g, exp);
            end
            for (int i = 0; i < 60; i++) begin
                en        = ($urandom_range(0, 1) != 0);
                rsp_ready = ($urandom_range(0, 1) != 0);
                pre = en && rsp_ready;
                tick();
                if (pre) break;
                tests_run++;
                if (rsp_valid !== 1'b1 || rsp_result !== exp) begin
                    tests_failed++;
                    $display("FAIL rnd_hold%0d: valid %0d %0h expected 1 %0h", k, rsp_valid, rsp_result, exp);
                end
            end
            rsp_ready = 1'b0;
            en = 1'b1;
            m_count = (m_count + 1) % (1 << CW);
            tests_run++;
            if (rsp_valid !== 1'b0 || done_count !== CW'(m_count)) begin
                tests_failed++;
                $display("FAIL rnd_count%0d: valid %0d count %0d expected 0 %0d", k, rsp_valid, done_count, m_count);
            end
        end
    endtask

    task automatic test_count_wrap();
        bit ok; int n;
        apply_reset();
        for (int k = 0; k < (1 << CW) - 1; k++) begin
            start_op(1'b0, k, 3, ok);
            wait_rsp(n, ok);
            handshake();
        end
        tests_run++;
        if (done_count !== CW'((1 << CW) - 1)) begin
            tests_failed++;
            $display("FAIL wrap_preload: got %0d expected %0d", done_count, (1 << CW) - 1);
        end
        start_op(1'b1, -1, -1, ok);
        wait_rsp(n, ok);
        handshake();
        tests_run++;
        if (!ok || done_count !== CW'(0) || done_count !== CW'(m_count)) begin
            tests_failed++;
            $display("FAIL wrap: got %0d expected 0", done_count);
        end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_basic();
        test_corners();
        test_backpressure();
        test_enable_stall();
        test_reset_mid_busy();
        test_random();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
